// File: rtl/pe_dot_stream_if.sv
// Operand/result bundle of the streaming dot-product element.
// The slave side is the processing element; the master side drives it.
interface pe_dot_stream_if #(
    parameter int unsigned DW        = 16,
    parameter int unsigned LANES     = 4,
    parameter int unsigned MAX_BEATS = 256,
    parameter int unsigned OW        = 16
);
    localparam int unsigned AW = 2 * DW + $clog2(LANES * MAX_BEATS) + 1;
    localparam int unsigned LW = $clog2(MAX_BEATS) + 1;
    localparam int unsigned SW = $clog2(AW);

    logic                  start;
    logic [LW-1:0]         len_beats;
    logic [SW-1:0]         shift;
    logic                  round_en;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*DW-1:0]   row_data;
    logic [LANES*DW-1:0]   x_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [OW-1:0]         y;
    logic [AW-1:0]         y_full;
    logic                  sat;
    logic                  busy;

    modport master (
        output start, len_beats, shift, round_en, in_valid, row_data, x_data, out_ready,
        input  in_ready, out_valid, y, y_full, sat, busy
    );

    modport slave (
        input  start, len_beats, shift, round_en, in_valid, row_data, x_data, out_ready,
        output in_ready, out_valid, y, y_full, sat, busy
    );
endinterface

// File: rtl/pe_dot_stream.sv
// Streaming dot-product element: accumulates LANES products per accepted beat, then
// presents the shifted, rounded and saturated result under valid/ready.
module pe_dot_stream #(
    parameter int unsigned DW        = 16,
    parameter int unsigned LANES     = 4,
    parameter int unsigned MAX_BEATS = 256,
    parameter int unsigned OW        = 16
) (
    input logic             clk,
    input logic             rst,
    pe_dot_stream_if.slave  bus
);
    localparam int unsigned AW = 2 * DW + $clog2(LANES * MAX_BEATS) + 1;
    localparam int unsigned LW = $clog2(MAX_BEATS) + 1;
    localparam int unsigned SW = $clog2(AW);

    localparam logic signed [AW:0] YMAX = {{(AW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [AW:0] YMIN = {{(AW + 2 - OW){1'b1}}, {(OW - 1){1'b0}}};
    localparam logic [AW:0]        ONE  = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

    state_e                state_q;
    logic [LW-1:0]         len_q;
    logic [LW-1:0]         cnt_q;
    logic [SW-1:0]         shift_q;
    logic                  round_q;
    logic signed [AW-1:0]  acc_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [OW-1:0]         y_q;
    logic [AW-1:0]         y_full_q;
    logic                  sat_q;

    logic signed [2*DW-1:0] prod [LANES];
    logic signed [AW-1:0]   beat_sum;
    logic signed [AW-1:0]   acc_next;
    logic signed [AW-1:0]   post_in;
    logic [SW-1:0]          post_shift;
    logic                   post_round;
    logic [AW:0]            rnd_add;
    logic signed [AW:0]     t;
    logic signed [AW:0]     s;
    logic [OW-1:0]          y_c;
    logic                   sat_c;
    logic [LW-1:0]          len_in;
    logic                   accept;
    logic                   last_beat;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign prod[k] = $signed(bus.row_data[k*DW +: DW]) * $signed(bus.x_data[k*DW +: DW]);
    end

    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            beat_sum = beat_sum + {{(AW - 2 * DW){prod[k][2*DW-1]}}, prod[k]};
        end
    end

    assign acc_next  = acc_q + beat_sum;
    assign len_in    = (bus.len_beats > LW'(MAX_BEATS)) ? LW'(MAX_BEATS) : bus.len_beats;
    assign accept    = (state_q == StAcc) && bus.in_valid && in_ready_q;
    assign last_beat = (cnt_q == len_q - 1'b1);

    // In IDLE the post stage only serves a zero-length request, so it sees acc=0
    // with the shift/round controls straight from the request.
    always_comb begin
        post_in    = acc_next;
        post_shift = shift_q;
        post_round = round_q;
        if (state_q == StIdle) begin
            post_in    = '0;
            post_shift = bus.shift;
            post_round = bus.round_en;
        end
        rnd_add = '0;
        if (post_round && (post_shift != '0)) begin
            rnd_add = ONE << (post_shift - 1'b1);
        end
        t     = {post_in[AW-1], post_in} + rnd_add;
        s     = t >>> post_shift;
        y_c   = s[OW-1:0];
        sat_c = 1'b0;
        if (s > YMAX) begin
            y_c   = YMAX[OW-1:0];
            sat_c = 1'b1;
        end else if (s < YMIN) begin
            y_c   = YMIN[OW-1:0];
            sat_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            round_q     <= 1'b0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            y_full_q    <= '0;
            sat_q       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        len_q   <= len_in;
                        shift_q <= bus.shift;
                        round_q <= bus.round_en;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        if (len_in == '0) begin
                            state_q     <= StOut;
                            out_valid_q <= 1'b1;
                            y_q         <= y_c;
                            y_full_q    <= '0;
                            sat_q       <= sat_c;
                        end else begin
                            state_q    <= StAcc;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                StAcc: begin
                    if (accept) begin
                        acc_q <= acc_next;
                        cnt_q <= cnt_q + 1'b1;
                        if (last_beat) begin
                            state_q     <= StOut;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            y_q         <= y_c;
                            y_full_q    <= acc_next;
                            sat_q       <= sat_c;
                        end
                    end
                end
                StOut: begin
                    if (bus.out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.y_full    = y_full_q;
    assign bus.sat       = sat_q;
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_pe_dot_stream.sv
// Directed bench for pe_dot_stream: expected results are queued at issue time and a
// negedge monitor checks each output handshake against the queue head.
module tb_pe_dot_stream;
    localparam int unsigned DW        = 16;
    localparam int unsigned LANES     = 4;
    localparam int unsigned MAX_BEATS = 256;
    localparam int unsigned OW        = 16;
    localparam int unsigned AW        = 2 * DW + $clog2(LANES * MAX_BEATS) + 1;
    localparam int unsigned LW        = $clog2(MAX_BEATS) + 1;
    localparam int unsigned SW        = $clog2(AW);

    typedef struct packed {
        logic [OW-1:0] y;
        logic [AW-1:0] full;
        logic          sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    pe_dot_stream_if #(.DW(DW), .LANES(LANES), .MAX_BEATS(MAX_BEATS), .OW(OW)) bus ();

    pe_dot_stream #(.DW(DW), .LANES(LANES), .MAX_BEATS(MAX_BEATS), .OW(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic logic [LANES*DW-1:0] pk(input int a, input int b, input int c, input int d);
        return {d[DW-1:0], c[DW-1:0], b[DW-1:0], a[DW-1:0]};
    endfunction

    function automatic exp_t mk(input longint yv, input longint fv, input bit s);
        exp_t e;
        e.y    = yv[OW-1:0];
        e.full = fv[AW-1:0];
        e.sat  = s;
        return e;
    endfunction

    // Scoreboard monitor: compares every output handshake with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected result", 64'(bus.y_full), 64'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("y", 64'(bus.y), 64'(e.y));
                check("y_full", 64'(bus.y_full), 64'(e.full));
                check("sat", 64'(bus.sat), 64'(e.sat));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input int len, input int sh, input bit rnd);
        bus.start     = 1'b1;
        bus.len_beats = LW'(len);
        bus.shift     = SW'(sh);
        bus.round_en  = rnd;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_beat(input logic [LANES*DW-1:0] r, input logic [LANES*DW-1:0] x);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.row_data = r;
        bus.x_data   = x;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        bus.in_valid = 1'b0;
        if (!ok) check("beat accept timeout", 64'(ok), 64'd1);
    endtask

    task automatic finish_op(input string name);
        bit seen = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        tick();
        bus.out_ready = 1'b0;
        check({name, " out_valid seen"}, 64'(seen), 64'd1);
        check({name, " out_valid cleared"}, 64'(bus.out_valid), 64'd0);
        check({name, " busy cleared"}, 64'(bus.busy), 64'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.len_beats = '0;
        bus.shift     = '0;
        bus.round_en  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.row_data  = '0;
        bus.x_data    = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("reset in_ready", 64'(bus.in_ready), 64'd0);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset y", 64'(bus.y), 64'd0);
        check("reset y_full", 64'(bus.y_full), 64'd0);
        check("reset sat", 64'(bus.sat), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        rst = 1'b0;
        tick();

        // Basic two-beat sum: 10 + 26 = 36, one-cycle latency from the last beat.
        sb.push_back(mk(36, 36, 0));
        start_op(2, 0, 0);
        check("basic in_ready after start", 64'(bus.in_ready), 64'd1);
        send_beat(pk(1, 1, 1, 1), pk(1, 2, 3, 4));
        check("basic no early valid", 64'(bus.out_valid), 64'd0);
        send_beat(pk(1, 1, 1, 1), pk(5, 6, 7, 8));
        check("basic latency", 64'(bus.out_valid), 64'd1);
        check("basic in_ready drop", 64'(bus.in_ready), 64'd0);
        finish_op("basic");

        // Saturation both ways.
        sb.push_back(mk(32767, 64'd4294705156, 1));
        start_op(1, 0, 0);
        send_beat(pk(32767, 32767, 32767, 32767), pk(32767, 32767, 32767, 32767));
        finish_op("sat pos");
        sb.push_back(mk(-32768, -64'sd4294836224, 1));
        start_op(1, 0, 0);
        send_beat(pk(-32768, -32768, -32768, -32768), pk(32767, 32767, 32767, 32767));
        finish_op("sat neg");

        // Rounding: 6>>2 and -6>>2 with and without half-up rounding.
        sb.push_back(mk(2, 6, 0));
        start_op(1, 2, 1);
        send_beat(pk(1, 1, 1, 1), pk(1, 2, 3, 0));
        finish_op("round pos on");
        sb.push_back(mk(1, 6, 0));
        start_op(1, 2, 0);
        send_beat(pk(1, 1, 1, 1), pk(1, 2, 3, 0));
        finish_op("round pos off");
        sb.push_back(mk(-1, -6, 0));
        start_op(1, 2, 1);
        send_beat(pk(1, 1, 1, 1), pk(-1, -2, -3, 0));
        finish_op("round neg on");
        sb.push_back(mk(-2, -6, 0));
        start_op(1, 2, 0);
        send_beat(pk(1, 1, 1, 1), pk(-1, -2, -3, 0));
        finish_op("round neg off");
        // Wide shift brings a large sum back into range: (4294705156 + 2^19) >> 20 = 4096.
        sb.push_back(mk(4096, 64'd4294705156, 0));
        start_op(1, 20, 1);
        send_beat(pk(32767, 32767, 32767, 32767), pk(32767, 32767, 32767, 32767));
        finish_op("wide shift");

        // Backpressure: gaps in in_valid carry junk data; 4 + 8 + 10 = 22.
        sb.push_back(mk(22, 22, 0));
        start_op(3, 0, 0);
        bus.in_valid = 1'b1; bus.row_data = pk(1, 1, 1, 1); bus.x_data = pk(1, 1, 1, 1); tick();
        bus.in_valid = 1'b0; bus.row_data = pk(100, 100, 100, 100); bus.x_data = pk(9, 9, 9, 9); tick();
        bus.in_valid = 1'b1; bus.row_data = pk(2, 2, 2, 2); bus.x_data = pk(1, 1, 1, 1); tick();
        bus.in_valid = 1'b0; bus.row_data = pk(100, 100, 100, 100); bus.x_data = pk(9, 9, 9, 9); tick();
        bus.in_valid = 1'b1; bus.row_data = pk(1, 1, 1, 1); bus.x_data = pk(10, 0, 0, 0); tick();
        check("bp valid after 3rd beat", 64'(bus.out_valid), 64'd1);
        bus.row_data = pk(100, 100, 100, 100);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp hold out_valid", 64'(bus.out_valid), 64'd1);
            check("bp hold y", 64'(bus.y), 64'd22);
            check("bp hold y_full", 64'(bus.y_full), 64'd22);
        end
        bus.in_valid = 1'b0;
        finish_op("bp");
        check("bp y retained", 64'(bus.y), 64'd22);

        // Zero-length request with in_valid held high: nothing may be consumed.
        sb.push_back(mk(0, 0, 0));
        bus.in_valid = 1'b1; bus.row_data = pk(5, 5, 5, 5); bus.x_data = pk(5, 5, 5, 5);
        start_op(0, 3, 1);
        check("len0 out_valid", 64'(bus.out_valid), 64'd1);
        check("len0 in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b0;
        finish_op("len0");

        // start during ACC must not restart: 10 + 8 = 18.
        sb.push_back(mk(18, 18, 0));
        start_op(2, 0, 0);
        send_beat(pk(1, 1, 1, 1), pk(1, 2, 3, 4));
        bus.start = 1'b1; bus.len_beats = LW'(1); tick(); bus.start = 1'b0;
        check("restart ignored in_ready", 64'(bus.in_ready), 64'd1);
        send_beat(pk(2, 2, 2, 2), pk(1, 1, 1, 1));
        check("restart ignored valid", 64'(bus.out_valid), 64'd1);
        finish_op("restart");

        // Reset mid-ACC clears everything; a fresh op afterwards is clean.
        start_op(3, 0, 0);
        send_beat(pk(1, 1, 1, 1), pk(1, 2, 3, 4));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid rst in_ready", 64'(bus.in_ready), 64'd0);
        check("mid rst busy", 64'(bus.busy), 64'd0);
        check("mid rst out_valid", 64'(bus.out_valid), 64'd0);
        check("mid rst y", 64'(bus.y), 64'd0);
        check("mid rst y_full", 64'(bus.y_full), 64'd0);
        sb.push_back(mk(10, 10, 0));
        start_op(1, 0, 0);
        send_beat(pk(1, 1, 1, 1), pk(1, 2, 3, 4));
        finish_op("post rst");

        // Over-long request clamps to MAX_BEATS beats of 1 each.
        sb.push_back(mk(MAX_BEATS, MAX_BEATS, 0));
        start_op(300, 0, 0);
        for (int i = 0; i < int'(MAX_BEATS); i++) begin
            send_beat(pk(1, 1, 1, 1), pk(1, 0, 0, 0));
            if (i == int'(MAX_BEATS) - 2) check("clamp no early valid", 64'(bus.out_valid), 64'd0);
        end
        check("clamp valid", 64'(bus.out_valid), 64'd1);
        finish_op("clamp");

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
